// File: rtl/pulse_decoder_if.sv
// Bundles the pulse line under decode with the per-burst result outputs.
// Latency: none, wires only.
// Backpressure: none; results are strobed or held, never handshaken.
//
// Signals:
//   signal  - raw pulse line (driven by the generator side)
//   busy    - burst in progress
//   done    - one-cycle strobe at burst end
//   pulses  - pulse count of the last completed burst (saturates at 15)
//   match   - last burst had the expected count and no interval error
//   error   - last burst contained an illegal interval
//
// Modports:
//   master - generator/consumer side: drives signal, observes results
//   slave  - decoder side: samples signal, drives results
interface pulse_decoder_if;
   logic       signal;
   logic       busy;
   logic       done;
   logic [3:0] pulses;
   logic       match;
   logic       error;

   modport master (
      output signal,
      input  busy,
      input  done,
      input  pulses,
      input  match,
      input  error
   );

   modport slave (
      input  signal,
      output busy,
      output done,
      output pulses,
      output match,
      output error
   );
endinterface

// File: rtl/pulse_decoder.sv
// Measures high/low intervals on a pulse line and reports per-burst count/range/match.
// Latency: done asserts IDLE_W+2 cycles after the last falling edge of the input line.
// Backpressure: none; done is a single-cycle strobe, result fields hold until next burst end.
//
// Ports:
//   clock   - single clock, all state on posedge
//   reset_n - synchronous active-low reset
//   bus     - pulse_decoder_if.slave: signal in; busy, done, pulses, match, error out
module pulse_decoder #(
   parameter int MIN_W  = 2,   // shortest legal high/low interval
   parameter int MAX_W  = 4,   // longest legal interval inside a burst
   parameter int IDLE_W = 8,   // same-level run that terminates a burst (> MAX_W)
   parameter int EXPECT = 3    // pulse count that constitutes a match
) (
   input  logic           clock,
   input  logic           reset_n,
   pulse_decoder_if.slave bus
);

   localparam int WW = $clog2(IDLE_W + 1);

   localparam logic [WW-1:0] MIN_V  = WW'(MIN_W);
   localparam logic [WW-1:0] MAX_V  = WW'(MAX_W);
   localparam logic [WW-1:0] LAST_V = WW'(IDLE_W - 1);
   localparam logic [WW-1:0] SAT_V  = WW'(IDLE_W);
   localparam logic [3:0]    EXP_V  = 4'(EXPECT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t        state;

   // Synchronizer: s1 may be metastable, s2 is the clean sample, s3 its history.
   logic          s1;
   logic          s2;
   logic          s3;
   logic          rise;
   logic          fall;

   logic [WW-1:0] width;
   logic [3:0]    cnt;
   logic          err;
   logic          width_bad;

   logic          busy_q;
   logic          done_q;
   logic [3:0]    pulses_q;
   logic          match_q;
   logic          error_q;

   assign rise      = s2 & ~s3;
   assign fall      = ~s2 & s3;

   // The interval that just closed is out of the legal in-burst range.
   assign width_bad = (width < MIN_V) || (width > MAX_V);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
         state    <= IDLE;
         width    <= '0;
         cnt      <= '0;
         err      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pulses_q <= '0;
         match_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         s1     <= bus.signal;
         s2     <= s1;
         s3     <= s2;
         done_q <= 1'b0;

         case (state)
            IDLE: begin
               // Only a genuine low-to-high edge opens a burst, so a line that
               // is still high after a stuck-high abort stays ignored.
               if (rise) begin
                  cnt    <= 4'd1;
                  err    <= 1'b0;
                  width  <= WW'(1);
                  state  <= HIGH;
                  busy_q <= 1'b1;
               end
            end

            HIGH: begin
               if (fall) begin
                  if (width_bad) begin
                     err <= 1'b1;
                  end
                  width <= WW'(1);
                  state <= LOW;
               end else if (width == LAST_V) begin
                  // Stuck high: abort the burst, always flagged as an error.
                  width    <= SAT_V;
                  err      <= 1'b1;
                  state    <= IDLE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  pulses_q <= cnt;
                  error_q  <= 1'b1;
                  match_q  <= 1'b0;
               end else begin
                  width <= width + 1'b1;
               end
            end

            LOW: begin
               if (rise) begin
                  if (width_bad) begin
                     err <= 1'b1;
                  end
                  if (cnt != 4'hF) begin
                     cnt <= cnt + 4'd1;
                  end
                  width <= WW'(1);
                  state <= HIGH;
               end else if (width == LAST_V) begin
                  // Terminating gap: normal end of burst. The gap itself is
                  // never range-checked, it is only the delimiter.
                  width    <= SAT_V;
                  state    <= IDLE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  pulses_q <= cnt;
                  error_q  <= err;
                  match_q  <= (cnt == EXP_V) && !err;
               end else begin
                  width <= width + 1'b1;
               end
            end

            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.pulses = pulses_q;
   assign bus.match  = match_q;
   assign bus.error  = error_q;

endmodule

// File: doc/pulse_decoder.md
# pulse_decoder

Receive-side counterpart of the pulse-train generator. It samples a single-bit pulse line and measures every high and low interval in clock cycles. It groups pulses into bursts separated by an idle gap, and reports per burst the pulse count, whether every interval was in range, and whether the burst matched the expected pulse count. It sits between any generator output (pulse1-style sources) and downstream control or checker logic.

## Interface
- MIN_W, default 2: minimum legal high or low interval, in cycles
- MAX_W, default 4: maximum legal high or low interval inside a burst, in cycles
- IDLE_W, default 8: consecutive same-level cycles that end a burst; must satisfy IDLE_W > MAX_W
- EXPECT, default 3: pulse count that constitutes a match
- clock, input, 1: single clock; all state updates on posedge
- reset_n, input, 1: reset, synchronous and active-low
- signal, input, 1: asynchronous pulse line under decode
- busy, output, 1: high while a burst is in progress (state != IDLE)
- done, output, 1: one-cycle strobe at burst end
- pulses, output, 4: pulse count of the last completed burst, saturating at 15
- match, output, 1: last burst had pulses == EXPECT and no interval error
- error, output, 1: last burst contained at least one illegal interval

## Operation
- Synchronizer:
  - s1 <= signal, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - All decoding uses s2 only.
- Internal state:
  - width counter, ceil(log2(IDLE_W+1)) bits, saturating at IDLE_W
  - running count cnt, 4 bits, saturating at 15
  - sticky burst-error bit err
- State machine, states IDLE, HIGH, LOW:
  - IDLE:
    - On rise: cnt=1, err=0, width=1, go to HIGH.
    - Otherwise stay. A line that is already high on entry does not start a burst; a fall then a rise is required.
  - HIGH:
    - While s2=1: width++.
    - When width reaches IDLE_W: stuck high. End the burst with err forced to 1 and go to IDLE.
    - On fall: if width < MIN_W or width > MAX_W, set err. Then width=1, go to LOW.
  - LOW:
    - While s2=0: width++.
    - When width reaches IDLE_W: end the burst normally and go to IDLE.
    - On rise: if width < MIN_W or width > MAX_W, set err. Then cnt++ (saturating), width=1, go to HIGH.
- Burst end, in the same cycle as the transition to IDLE:
  - done=1 for exactly one cycle
  - pulses=cnt
  - error=err (including the stuck-high force)
  - match=(cnt==EXPECT) & ~err_final
- pulses, match and error hold their values until the next burst end.
- The final low gap is not checked against MAX_W; it is the terminator.
- A high interval > MAX_W but < IDLE_W sets err and decoding continues.
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; s1, s2, s3, width, cnt and err cleared
  - busy, done, pulses, match and error all 0
  - Applies mid-burst: the partial burst is discarded and no done is produced.

## Timing
- A level change on signal that is stable before edge k appears on s2 after edge k+1.
- The FSM acts on it at edge k+2.
- Measured widths equal the input widths in cycles when signal changes synchronously to the clock.
- done rises 1 cycle after the edge that samples the IDLE_W-th consecutive terminating s2 level.
- End-to-end, done asserts IDLE_W+2 cycles after the last falling input edge.
- busy rises 1 cycle after the FSM sees rise and falls together with done.
- No back-pressure: done is a strobe and is never held.
- Outputs are registered with no combinational path from signal.

## Test plan
- Reset:
  - Hold reset_n=0 for 3 cycles with signal toggling.
  - Required: busy, done, pulses, match and error all 0, and no done for 10 cycles after release while signal=0.
- Nominal burst:
  - Drive high 3, low 3, high 3, low 3, high 3, then low 12 cycles.
  - Required: exactly one done, pulses=3, match=1, error=0, busy low again after done.
- Short interval:
  - Same as nominal, but the second high lasts 1 cycle.
  - Required: pulses=3, error=1, match=0.
- Wrong count:
  - Drive two nominal pulses (high 3, low 3, high 3), then low 12.
  - Required: pulses=2, error=0, match=0.
- Stuck high:
  - Drive high for 15 cycles.
  - Required: done 8 cycles after s2 goes high (IDLE_W), pulses=1, error=1, match=0.
  - Then low 5, followed by a nominal burst: decoded as pulses=3, match=1.
- Reset mid-burst:
  - Pull reset_n low for 1 cycle after the second pulse.
  - Required: busy=0, no done for that burst, outputs 0.
  - A following nominal burst then gives pulses=3, match=1.
